armleocpu_regfile_wb_arbiter: RTL and testbench

// Shares the register file's single write port (rd_addr/rd_data/rd_write) between
// NUM_REQ writeback sources (e.g. ALU, load unit, CSR unit).
// - Arbitration is round-robin with valid/ready handshakes.
// - The selected write is registered onto the rd port.
// - A 32-entry pending-write scoreboard (busy) lets issue logic detect RAW hazards.

---
 rtl/armleocpu_regfile_wb_arbiter.sv | 87 ++++++++
 tb/tb_armleocpu_regfile_wb_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/armleocpu_regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port between NUM_REQ writeback
// sources, with a registered rd port and a 32-entry pending-write scoreboard.
//
// Ports:
//   clk, async_rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready          per-requester handshake (ready is combinational)
//   req_addr[i*5+:5]             destination register of requester i
//   req_data[i*32+:32]           write data of requester i
//   reserve_valid/reserve_addr   issue logic marks a register as pending
//   rd_write/rd_addr/rd_data     registered regfile write port
//   busy                         pending-write bitmap, bit 0 always 0
module armleocpu_regfile_wb_arbiter #(
   parameter int NUM_REQ = 3
) (
   input  logic                    clk,
   input  logic                    async_rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*5-1:0]    req_addr,
   input  logic [NUM_REQ*32-1:0]   req_data,
   input  logic                    reserve_valid,
   input  logic [4:0]              reserve_addr,
   output logic                    rd_write,
   output logic [4:0]              rd_addr,
   output logic [31:0]             rd_data,
   output logic [31:0]             busy
);

   localparam int PW = $clog2(NUM_REQ);

   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] ptr_nxt;
   logic          found;
   int            idx;
   int            win_i;
   logic [4:0]    win_addr;
   logic [31:0]   win_data;
   logic [31:0]   busy_nxt;

   // Scan from rr_ptr upward; the first valid requester wins.
   always_comb begin
      req_ready = '0;
      found     = 1'b0;
      win_i     = 0;
      idx       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (!found && req_valid[idx]) begin
            found          = 1'b1;
            win_i          = idx;
            req_ready[idx] = async_rst_n;
         end
      end
      win_addr = req_addr[win_i*5 +: 5];
      win_data = req_data[win_i*32 +: 32];
      ptr_nxt  = PW'((win_i + 1) % NUM_REQ);
   end

   // Set is applied after clear so a same-cycle re-reservation stays busy.
   always_comb begin
      busy_nxt = busy;
      if (rd_write)
         busy_nxt[rd_addr] = 1'b0;
      if (reserve_valid)
         busy_nxt[reserve_addr] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         rr_ptr   <= '0;
         rd_write <= 1'b0;
         rd_addr  <= '0;
         rd_data  <= '0;
         busy     <= '0;
      end else begin
         busy     <= busy_nxt;
         rd_write <= found && (win_addr != 5'd0);
         if (found) begin
            rr_ptr  <= ptr_nxt;
            rd_addr <= win_addr;
            rd_data <= win_data;
         end
      end
   end

endmodule

// File: tb/tb_armleocpu_regfile_wb_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// every cycle against a behavioural model of the arbiter and scoreboard.
module tb_armleocpu_regfile_wb_arbiter;

   localparam int N = 3;

   logic            clk = 1'b0;
   logic            async_rst_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*5-1:0]  req_addr;
   logic [N*32-1:0] req_data;
   logic            reserve_valid;
   logic [4:0]      reserve_addr;
   logic            rd_write;
   logic [4:0]      rd_addr;
   logic [31:0]     rd_data;
   logic [31:0]     busy;

   armleocpu_regfile_wb_arbiter #(.NUM_REQ(N)) dut (
      .clk(clk),
      .async_rst_n(async_rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_addr(req_addr),
      .req_data(req_data),
      .reserve_valid(reserve_valid),
      .reserve_addr(reserve_addr),
      .rd_write(rd_write),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Behavioural model state
   int          m_ptr;
   bit          m_rdw;
   bit [4:0]    m_addr;
   bit [31:0]   m_data;
   bit [31:0]   m_busy;
   bit [N-1:0]  m_gnt;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ptr  = 0;
      m_rdw  = 0;
      m_addr = '0;
      m_data = '0;
      m_busy = '0;
      m_gnt  = '0;
   endtask

   function automatic int m_winner();
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_ptr + k) % N;
         if (req_valid[i]) return i;
      end
      return -1;
   endfunction

   task automatic set_req(int i, logic [4:0] a, logic [31:0] d);
      req_valid[i]         = 1'b1;
      req_addr[i*5 +: 5]   = a;
      req_data[i*32 +: 32] = d;
   endtask

   // Compare at negedge, advance the model, then return just after posedge.
   task automatic step();
      int w;
      logic [N-1:0] eg;
      @(negedge clk);
      w  = m_winner();
      eg = '0;
      if (w >= 0) eg[w] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(eg));
      chk("rd_write", 32'(rd_write), 32'(m_rdw));
      chk("rd_addr", 32'(rd_addr), 32'(m_addr));
      chk("rd_data", rd_data, m_data);
      chk("busy", busy, m_busy);
      m_gnt = eg;
      if (m_rdw) m_busy[m_addr] = 1'b0;
      if (reserve_valid && reserve_addr != 5'd0)
         m_busy[reserve_addr] = 1'b1;
      if (w >= 0) begin
         m_rdw  = req_addr[w*5 +: 5] != 5'd0;
         m_addr = req_addr[w*5 +: 5];
         m_data = req_data[w*32 +: 32];
         m_ptr  = (w + 1) % N;
      end else begin
         m_rdw = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [N-1:0] exp_g [4];
      exp_g[0] = 3'b001;
      exp_g[1] = 3'b010;
      exp_g[2] = 3'b100;
      exp_g[3] = 3'b001;

      model_reset();
      async_rst_n   = 1'b0;
      req_valid     = 3'b111;
      req_addr      = '0;
      req_data      = '0;
      reserve_valid = 1'b0;
      reserve_addr  = '0;

      // Reset state, with valid requests present
      repeat (2) @(posedge clk);
      #2;
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_rd_write", 32'(rd_write), 32'h0);
      chk("rst_busy", busy, 32'h0);
      req_valid = '0;
      @(posedge clk);
      #1;
      async_rst_n = 1'b1;

      // Single write from requester 0
      set_req(0, 5'd5, 32'hFF00FF00);
      #1;
      chk("t2_ready", 32'(req_ready), 32'h1);
      step();
      req_valid = '0;
      chk("t2_rd_write", 32'(rd_write), 32'h1);
      chk("t2_rd_addr", 32'(rd_addr), 32'd5);
      chk("t2_rd_data", rd_data, 32'hFF00FF00);

      // Bring the pointer back to 0 via requester 2
      set_req(2, 5'd9, 32'h99);
      step();
      req_valid = '0;

      // All three held valid: rotating grants, no bubbles
      set_req(0, 5'd1, 32'h101);
      set_req(1, 5'd2, 32'h102);
      set_req(2, 5'd3, 32'h103);
      for (int g = 0; g < 4; g++) begin
         #1;
         chk("t3_grant", 32'(req_ready), 32'(exp_g[g]));
         step();
         chk("t3_rd_write", 32'(rd_write), 32'h1);
         chk("t3_rd_addr", 32'(rd_addr), 32'(g % 3 + 1));
      end
      req_valid = '0;

      // Write to x0 accepted but discarded, pointer still advances
      set_req(1, 5'd0, 32'hDEAD);
      #1;
      chk("t4_ready", 32'(req_ready), 32'h2);
      step();
      req_valid = '0;
      chk("t4_rd_write", 32'(rd_write), 32'h0);
      set_req(0, 5'd1, 32'h1);
      set_req(1, 5'd2, 32'h2);
      set_req(2, 5'd3, 32'h3);
      #1;
      chk("t4_ptr", 32'(req_ready), 32'h4);
      req_valid = '0;

      // Scoreboard
      reserve_valid = 1'b1;
      reserve_addr  = 5'd7;
      step();
      reserve_valid = 1'b0;
      chk("t5_set", 32'(busy[7]), 32'h1);
      set_req(0, 5'd7, 32'h77);
      step();
      req_valid = '0;
      chk("t5_wb_write", 32'(rd_write), 32'h1);
      chk("t5_still_busy", 32'(busy[7]), 32'h1);
      step();
      chk("t5_clear", 32'(busy[7]), 32'h0);
      reserve_valid = 1'b1;
      step();
      reserve_valid = 1'b0;
      set_req(0, 5'd7, 32'h78);
      step();
      req_valid     = '0;
      reserve_valid = 1'b1;
      step();
      reserve_valid = 1'b0;
      chk("t5_set_wins", 32'(busy[7]), 32'h1);
      reserve_valid = 1'b1;
      reserve_addr  = 5'd0;
      step();
      reserve_valid = 1'b0;
      chk("t5_x0", 32'(busy[0]), 32'h0);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && m_gnt[i]) req_valid[i] = 1'b0;
            if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
               logic [4:0] a;
               a = 5'($urandom_range(0, 31));
               if ($urandom_range(0, 7) == 0) a = 5'd0;
               set_req(i, a, $urandom());
            end
         end
         reserve_valid = $urandom_range(0, 2) == 0;
         reserve_addr  = 5'($urandom_range(0, 31));
         step();
      end
      req_valid     = '0;
      reserve_valid = 1'b0;
      step();

      // Asynchronous reset mid-stream
      reserve_valid = 1'b1;
      reserve_addr  = 5'd12;
      step();
      reserve_valid = 1'b0;
      set_req(0, 5'd4, 32'h4);
      set_req(1, 5'd5, 32'h5);
      set_req(2, 5'd6, 32'h6);
      step();
      step();
      chk("t6_pre_write", 32'(rd_write), 32'h1);
      chk("t6_pre_busy", 32'(busy[12]), 32'h1);
      #2;
      async_rst_n = 1'b0;
      #1;
      chk("t6_rd_write", 32'(rd_write), 32'h0);
      chk("t6_busy", busy, 32'h0);
      chk("t6_ready", 32'(req_ready), 32'h0);
      model_reset();
      @(posedge clk);
      #1;
      async_rst_n = 1'b1;
      #1;
      chk("t6_first_grant", 32'(req_ready), 32'h1);
      step();
      step();
      req_valid = '0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
